// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: control/redirect inputs, program-memory read port and decode outputs.
// Optional FETCH_PERF_CNT_EN adds the retired/cycle performance counters.
interface instr_fetch_if #(
  parameter int unsigned W    = 9,
  parameter int unsigned AW   = 9,
  parameter int unsigned OFFW = 6
);
  logic            start;
  logic            stall;
  logic            jump_en;
  logic [AW-1:0]   jump_target;
  logic            branch_taken;
  logic [OFFW-1:0] branch_off;
  logic [W-1:0]    instr_in;
  logic [AW-1:0]   raddr;
  logic [W-1:0]    instr_out;
  logic            instr_valid;
  logic            done;
  logic            overrun;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]     retired_cnt;
  logic [15:0]     cycle_cnt;
`endif

  // Fetch unit side
  modport master (
    input  start, stall, jump_en, jump_target, branch_taken, branch_off, instr_in,
    output raddr, instr_out, instr_valid, done, overrun
`ifdef FETCH_PERF_CNT_EN
    , output retired_cnt, cycle_cnt
`endif
  );

  // Core / memory side
  modport slave (
    output start, stall, jump_en, jump_target, branch_taken, branch_off, instr_in,
    input  raddr, instr_out, instr_valid, done, overrun
`ifdef FETCH_PERF_CNT_EN
    , input retired_cnt, cycle_cnt
`endif
  );
endinterface

// File: rtl/instr_fetch.sv
// Program counter and fetch sequencer for the 512x9 program memory.
// IDLE -> RUN on start; RUN -> HALT on HALT_WORD or PC overrun; HALT -> RUN on start.
// Optional macro FETCH_PERF_CNT_EN adds saturating retired/cycle counters.
module instr_fetch #(
  parameter int unsigned     W          = 9,
  parameter int unsigned     DEPTH      = 512,
  parameter int unsigned     OFFW       = 6,
  parameter int unsigned     START_ADDR = 0,
  parameter logic [W-1:0]    HALT_WORD  = 9'h1FF
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master fetch_if
);
  localparam int unsigned   AW         = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] START_PC   = AW'(START_ADDR);
  localparam logic [AW:0]   DEPTH_EXT  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          overrun_q, overrun_d;

  logic [AW-1:0] br_off_ext;
  logic [AW-1:0] redir_addr;
  logic          redirect;
  logic          redir_oob;
  logic          run;

  assign run = (state_q == ST_RUN);

  // Redirect target: absolute jump wins over relative branch; branch wraps modulo 2^AW
  always_comb begin
    br_off_ext = {{(AW-OFFW){fetch_if.branch_off[OFFW-1]}}, fetch_if.branch_off};
    redirect   = fetch_if.jump_en | fetch_if.branch_taken;
    redir_addr = fetch_if.jump_en ? fetch_if.jump_target : (pc_q + br_off_ext);
    redir_oob  = ({1'b0, redir_addr} >= DEPTH_EXT);
  end

  // Fetch sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      overrun_q <= overrun_d;
    end
  end

  // Next state / next PC: stall > halt word > jump > branch > increment
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    overrun_d = overrun_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (fetch_if.start) begin
          state_d   = ST_RUN;
          pc_d      = START_PC;
          overrun_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!fetch_if.stall) begin
          if (fetch_if.instr_in == HALT_WORD) begin
            state_d = ST_HALT;
          end else if (redirect) begin
            if (redir_oob) begin
              state_d   = ST_HALT;
              overrun_d = 1'b1;
            end else begin
              pc_d = redir_addr;
            end
          end else if (pc_q == LAST_ADDR) begin
            state_d   = ST_HALT;
            overrun_d = 1'b1;
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode-facing outputs; instruction passes straight through from memory in RUN
  always_comb begin
    fetch_if.raddr       = pc_q;
    fetch_if.instr_out   = run ? fetch_if.instr_in : '0;
    fetch_if.instr_valid = run & ~fetch_if.stall;
    fetch_if.done        = (state_q == ST_HALT);
    fetch_if.overrun     = overrun_q;
  end

`ifdef FETCH_PERF_CNT_EN
  localparam int unsigned    CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             accept_start;

  assign accept_start = (state_q != ST_RUN) & fetch_if.start;

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      retired_q <= retired_d;
      cycle_q   <= cycle_d;
    end
  end

  // Saturating counters, cleared on accepted start, frozen outside RUN
  always_comb begin
    retired_d = retired_q;
    cycle_d   = cycle_q;
    if (accept_start) begin
      retired_d = '0;
      cycle_d   = '0;
    end else if (run) begin
      if (cycle_q != CNT_MAX) cycle_d = cycle_q + CNT_W'(1);
      if (!fetch_if.stall && (retired_q != CNT_MAX)) retired_d = retired_q + CNT_W'(1);
    end
  end

  assign fetch_if.retired_cnt = retired_q;
  assign fetch_if.cycle_cnt   = cycle_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a behavioural program-counter model.
module tb_instr_fetch;
  localparam int unsigned W = 9, DEPTH = 512, AW = 9, OFFW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;

  instr_fetch_if #(.W(W), .AW(AW), .OFFW(OFFW)) bus ();

  instr_fetch #(.W(W), .DEPTH(DEPTH), .OFFW(OFFW), .START_ADDR(0), .HALT_WORD(9'h1FF)) dut (
    .clk      (clk),
    .reset    (reset),
    .fetch_if (bus.master)
  );

  logic [W-1:0] mem [DEPTH];
  assign bus.instr_in = mem[bus.raddr];

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Behavioural model: 0 idle, 1 running, 2 halted
  int          m_st;
  int unsigned m_pc;
  bit          m_ov;
  int unsigned m_ret, m_cyc;

  typedef struct {
    bit rst, start, stall, jen;
    int jt;
    bit btk;
    int bo;
    int e_raddr;
    bit e_valid;
    int e_iout;
    bit e_done, e_ov;
  } vec_t;

  vec_t tbl [30];

  function automatic vec_t mk(bit rst, bit st, bit sl, bit jen, int jt, bit btk, int bo,
                              int ra, bit vl, int io, bit dn, bit ov);
    vec_t v;
    v.rst = rst; v.start = st; v.stall = sl; v.jen = jen; v.jt = jt; v.btk = btk; v.bo = bo;
    v.e_raddr = ra; v.e_valid = vl; v.e_iout = io; v.e_done = dn; v.e_ov = ov;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input bit rst, input bit st, input bit sl, input bit jen, input int jt,
                       input bit btk, input int bo);
    @(negedge clk);
    reset            = rst;
    bus.start        = st;
    bus.stall        = sl;
    bus.jump_en      = jen;
    bus.jump_target  = AW'(jt);
    bus.branch_taken = btk;
    bus.branch_off   = OFFW'(bo);
    #1;
  endtask

  task automatic model_check();
    chk("raddr", 16'(bus.raddr), 16'(m_pc));
    chk("valid", 16'(bus.instr_valid), 16'((m_st == 1) && !bus.stall));
    chk("iout",  16'(bus.instr_out), (m_st == 1) ? 16'(mem[m_pc]) : 16'h0);
    chk("done",  16'(bus.done), 16'(m_st == 2));
    chk("ovr",   16'(bus.overrun), 16'(m_ov));
`ifdef FETCH_PERF_CNT_EN
    chk("retired", bus.retired_cnt, 16'(m_ret));
    chk("cycles",  bus.cycle_cnt, 16'(m_cyc));
`endif
  endtask

  // Advance the model by one clock using the currently driven inputs
  task automatic model_step();
    int off;
    if (reset) begin
      m_st = 0; m_pc = 0; m_ov = 0; m_ret = 0; m_cyc = 0;
    end else if (m_st != 1) begin
      if (bus.start) begin
        m_st = 1; m_pc = 0; m_ov = 0; m_ret = 0; m_cyc = 0;
      end
    end else begin
      if (m_cyc < 65535) m_cyc++;
      if (!bus.stall) begin
        if (m_ret < 65535) m_ret++;
        off = int'(bus.branch_off);
        if (off >= 32) off -= 64;
        if (mem[m_pc] == 9'h1FF) m_st = 2;
        else if (bus.jump_en) m_pc = int'(bus.jump_target);
        else if (bus.branch_taken) m_pc = (m_pc + 512 + off) % 512;
        else if (m_pc == DEPTH - 1) begin m_st = 2; m_ov = 1; end
        else m_pc++;
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit st, input bit sl, input bit jen, input int jt,
                     input bit btk, input int bo);
    apply(rst, st, sl, jen, jt, btk, bo);
    model_check();
    model_step();
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  int vcnt;

  initial begin
    clear_mem();
    // Power-up reset; outputs are unknown before the first edge so nothing is compared
    apply(1, 0, 0, 0, 0, 0, 0); model_step();
    apply(1, 0, 0, 0, 0, 0, 0); model_step();

    // Directed table: rst,start,stall,jen,jt,btk,bo | raddr,valid,iout,done,ovr
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h1FF; mem[7] = 9'h1FF;
    tbl[0]  = mk(0,0,0,0,  0,0, 0,   0,0,9'h000,0,0);
    tbl[1]  = mk(0,1,0,0,  0,0, 0,   0,0,9'h000,0,0);
    tbl[2]  = mk(0,0,0,0,  0,0, 0,   0,1,9'h001,0,0);
    tbl[3]  = mk(0,0,0,0,  0,0, 0,   1,1,9'h002,0,0);
    tbl[4]  = mk(0,0,0,0,  0,0, 0,   2,1,9'h1FF,0,0);
    tbl[5]  = mk(0,0,0,0,  0,0, 0,   2,0,9'h000,1,0);
    tbl[6]  = mk(0,1,0,0,  0,0, 0,   2,0,9'h000,1,0);
    tbl[7]  = mk(0,0,0,1, 10,0, 0,   0,1,9'h001,0,0);
    tbl[8]  = mk(0,0,0,0,  0,1,60,  10,1,9'h000,0,0);
    tbl[9]  = mk(0,0,0,1,  5,0, 0,   6,1,9'h000,0,0);
    tbl[10] = mk(0,0,0,0,  0,1, 3,   5,1,9'h000,0,0);
    tbl[11] = mk(0,0,0,1, 20,0, 0,   8,1,9'h000,0,0);
    tbl[12] = mk(0,0,1,1,300,1, 1,  20,0,9'h000,0,0);
    tbl[13] = mk(0,0,0,1,300,1, 1,  20,1,9'h000,0,0);
    tbl[14] = mk(0,0,0,0,  0,1,32, 300,1,9'h000,0,0);
    tbl[15] = mk(0,1,0,0,  0,0, 0, 268,1,9'h000,0,0);
    tbl[16] = mk(0,0,0,1,511,0, 0, 269,1,9'h000,0,0);
    tbl[17] = mk(0,0,0,0,  0,0, 0, 511,1,9'h000,0,0);
    tbl[18] = mk(0,0,0,0,  0,0, 0, 511,0,9'h000,1,1);
    tbl[19] = mk(0,1,0,0,  0,0, 0, 511,0,9'h000,1,1);
    tbl[20] = mk(0,0,0,1,  7,0, 0,   0,1,9'h001,0,0);
    tbl[21] = mk(0,0,0,1,100,0, 0,   7,1,9'h1FF,0,0);
    tbl[22] = mk(0,0,0,0,  0,0, 0,   7,0,9'h000,1,0);
    tbl[23] = mk(0,1,0,0,  0,0, 0,   7,0,9'h000,1,0);
    tbl[24] = mk(0,0,0,0,  0,1,63,   0,1,9'h001,0,0);
    tbl[25] = mk(0,0,1,0,  0,0, 0, 511,0,9'h000,0,0);
    tbl[26] = mk(0,0,0,0,  0,1, 1, 511,1,9'h000,0,0);
    tbl[27] = mk(1,1,0,0,  0,0, 0,   0,1,9'h001,0,0);
    tbl[28] = mk(0,0,0,0,  0,0, 0,   0,0,9'h000,0,0);
    tbl[29] = mk(0,0,0,0,  0,0, 0,   0,0,9'h000,0,0);
    for (int i = 0; i < 30; i++) begin
      apply(tbl[i].rst, tbl[i].start, tbl[i].stall, tbl[i].jen, tbl[i].jt, tbl[i].btk, tbl[i].bo);
      chk($sformatf("tbl%0d_raddr", i), 16'(bus.raddr),       16'(tbl[i].e_raddr));
      chk($sformatf("tbl%0d_valid", i), 16'(bus.instr_valid), 16'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_iout", i),  16'(bus.instr_out),   16'(tbl[i].e_iout));
      chk($sformatf("tbl%0d_done", i),  16'(bus.done),        16'(tbl[i].e_done));
      chk($sformatf("tbl%0d_ovr", i),   16'(bus.overrun),     16'(tbl[i].e_ov));
      model_check();
      model_step();
    end

    // Walk the whole memory of zeros into overrun
    clear_mem();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    vcnt = 0;
    for (int i = 0; i < 1000; i++) begin
      idle_cyc();
      if (bus.done) break;
      if (bus.instr_valid) vcnt++;
    end
    chk("walk_done", 16'(bus.done), 16'h1);
    chk("walk_raddr", 16'(bus.raddr), 16'd511);
    chk("walk_ovr", 16'(bus.overrun), 16'h1);
    chk("walk_fetches", 16'(vcnt), 16'd512);
`ifdef FETCH_PERF_CNT_EN
    chk("walk_retired", bus.retired_cnt, 16'd512);
    chk("walk_cycles", bus.cycle_cnt, 16'd512);
`endif
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle_cyc();
    chk("restart_raddr", 16'(bus.raddr), 16'd0);
    chk("restart_ovr", 16'(bus.overrun), 16'h0);

    // Reset while running at PC=42, start on the reset cycle ignored
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (42) idle_cyc();
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rst42_pre_raddr", 16'(bus.raddr), 16'd42);
    idle_cyc();
    chk("rst42_raddr", 16'(bus.raddr), 16'd0);
    chk("rst42_done", 16'(bus.done), 16'h0);
    chk("rst42_valid", 16'(bus.instr_valid), 16'h0);

    // Straight run into HALT_WORD at address 7 with a competing jump
    mem[7] = 9'h1FF;
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (7) idle_cyc();
    cyc(0, 0, 0, 1, 200, 0, 0);
    idle_cyc();
    chk("h7_done", 16'(bus.done), 16'h1);
    chk("h7_raddr", 16'(bus.raddr), 16'd7);
    chk("h7_ovr", 16'(bus.overrun), 16'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("h7_retired", bus.retired_cnt, 16'd8);
    chk("h7_cycles", bus.cycle_cnt, 16'd8);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < DEPTH; i++)
      mem[i] = ($urandom_range(0, 23) == 0) ? 9'h1FF : W'($urandom_range(0, 510));
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) == 0,
          int'($urandom_range(0, DEPTH - 1)),
          $urandom_range(0, 5) == 0,
          int'($urandom_range(0, 63)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
